// File: rtl/mem_req_responder.sv
// mem_req_responder: memory-side responder for the cache-to-SRAM request
// interface. Requests are served from an internal 16-bit block RAM. Each
// 32-bit word takes two halfword accesses, and each access is stretched by
// WAIT_CYCLES to mimic external PSRAM timing. Data requests are always
// served before instruction requests.

module mem_req_responder #(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ie,
   input  logic        de,
   input  logic [31:0] iaddr,
   input  logic [31:0] daddr,
   input  logic        drw,
   input  logic [31:0] din,
   output logic [31:0] iout,
   output logic [31:0] dout,
   output logic        rdy
);

   typedef enum logic [2:0] {
      IDLE,
      D_HI,
      D_LO,
      I_HI,
      I_LO,
      DONE
   } state_t;

   localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WAIT_CYCLES);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   state_t                  state;
   state_t                  state_next;
   logic [CW-1:0]           cnt;
   logic                    last;
   logic [ADDR_WIDTH-2:0]   d_idx;
   logic [ADDR_WIDTH-2:0]   i_idx;
   logic                    d_write;
   logic [31:0]             d_data;
   logic                    i_pend;

   logic [ADDR_WIDTH-1:0]   mem_idx;
   logic                    mem_we;
   logic [15:0]             mem_wdata;
   logic [15:0]             mem [0:DEPTH-1];

   // Address bits above the array and the byte offset are intentionally ignored.
   wire unused_addr_bits = ^{iaddr[31:ADDR_WIDTH+1], iaddr[1:0],
                             daddr[31:ADDR_WIDTH+1], daddr[1:0]};

   // The last cycle of an access window is when the halfword is transferred.
   assign last = (cnt == LAST_CNT);

   // Completion is decoded purely from the state register.
   assign rdy = (state == DONE);

   // State register and the wait counter, which restarts on every state entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         if ((state == D_HI || state == D_LO || state == I_HI || state == I_LO) && !last)
            cnt <= cnt + 1'b1;
         else
            cnt <= '0;
      end
   end

   // Next-state logic: data halves first, then instruction halves if pending.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (de)
               state_next = D_HI;
            else if (ie)
               state_next = I_HI;
         end
         D_HI: if (last) state_next = D_LO;
         D_LO: if (last) state_next = i_pend ? I_HI : DONE;
         I_HI: if (last) state_next = I_LO;
         I_LO: if (last) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Capture the request only in IDLE; later input changes are ignored.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         d_idx   <= '0;
         i_idx   <= '0;
         d_write <= 1'b0;
         d_data  <= '0;
         i_pend  <= 1'b0;
      end else if (state == IDLE) begin
         if (de) begin
            d_idx   <= daddr[ADDR_WIDTH:2];
            d_write <= drw;
            d_data  <= din;
            i_pend  <= ie;
            if (ie)
               i_idx <= iaddr[ADDR_WIDTH:2];
         end else if (ie) begin
            i_idx  <= iaddr[ADDR_WIDTH:2];
            i_pend <= 1'b0;
         end
      end
   end

   // Halfword index and write strobe for the single memory port.
   always_comb begin
      mem_idx   = '0;
      mem_we    = 1'b0;
      mem_wdata = d_data[31:16];
      case (state)
         D_HI: begin
            mem_idx = {d_idx, 1'b0};
            mem_we  = last && d_write;
         end
         D_LO: begin
            mem_idx   = {d_idx, 1'b1};
            mem_we    = last && d_write;
            mem_wdata = d_data[15:0];
         end
         I_HI: mem_idx = {i_idx, 1'b0};
         I_LO: mem_idx = {i_idx, 1'b1};
         default: mem_idx = '0;
      endcase
   end

   // Memory array write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (mem_we)
         mem[mem_idx] <= mem_wdata;
   end

   // Registered read: each output half is loaded at the end of its window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         iout <= '0;
         dout <= '0;
      end else if (last) begin
         case (state)
            D_HI: if (!d_write) dout[31:16] <= mem[mem_idx];
            D_LO: if (!d_write) dout[15:0]  <= mem[mem_idx];
            I_HI: iout[31:16] <= mem[mem_idx];
            I_LO: iout[15:0]  <= mem[mem_idx];
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_req_responder.sv
// Testbench for mem_req_responder: two instances (WAIT_CYCLES=2 and 0)
// checked against a word-level memory model and a latency formula.

module tb_mem_req_responder;

   logic        clk = 1'b0;
   logic        rst_a   [2];
   logic        ie_a    [2];
   logic        de_a    [2];
   logic        drw_a   [2];
   logic [31:0] iaddr_a [2];
   logic [31:0] daddr_a [2];
   logic [31:0] din_a   [2];
   logic [31:0] iout_a  [2];
   logic [31:0] dout_a  [2];
   logic        rdy_a   [2];

   int assert_count = 0;
   int fail_count   = 0;

   // Reference model: word-addressed memory plus the expected output registers.
   logic [31:0] mwords   [2][2048];
   logic [31:0] exp_iout [2];
   logic [31:0] exp_dout [2];

   // Free-running clock.
   always #5 clk = ~clk;

   mem_req_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) u_dut_w2 (
      .clk(clk), .rst(rst_a[0]), .ie(ie_a[0]), .de(de_a[0]),
      .iaddr(iaddr_a[0]), .daddr(daddr_a[0]), .drw(drw_a[0]), .din(din_a[0]),
      .iout(iout_a[0]), .dout(dout_a[0]), .rdy(rdy_a[0])
   );

   mem_req_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst_a[1]), .ie(ie_a[1]), .de(de_a[1]),
      .iaddr(iaddr_a[1]), .daddr(daddr_a[1]), .drw(drw_a[1]), .din(din_a[1]),
      .iout(iout_a[1]), .dout(dout_a[1]), .rdy(rdy_a[1])
   );

   function automatic int wait_of(input int inst);
      return (inst == 0) ? 2 : 0;
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'(a[12:2]);
   endfunction

   // A random alias of a word: upper address bits and byte offset scrambled.
   function automatic logic [31:0] alias_of(input int idx);
      logic [31:0] r;
      r = $urandom;
      return (r & 32'hFFFF_E003) | (32'(idx) << 2);
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      assert_count++;
      if (got !== exp) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // One complete request: drive, wait for rdy within a budget, update the model, check.
   task automatic applyStimulus(input int inst, input bit use_d, input bit use_i, input bit rw,
                                input logic [31:0] da, input logic [31:0] ia,
                                input logic [31:0] dd, input string tag);
      int k;
      int exp_lat;
      int cyc;
      bit got;
      k       = int'(use_d) + int'(use_i);
      exp_lat = 2 * k * (wait_of(inst) + 1);
      @(negedge clk);
      de_a[inst]    = use_d;
      ie_a[inst]    = use_i;
      drw_a[inst]   = rw;
      daddr_a[inst] = da;
      iaddr_a[inst] = ia;
      din_a[inst]   = dd;
      @(posedge clk);
      cyc = 0;
      got = 1'b0;
      while (cyc < exp_lat + 8 && !got) begin
         @(posedge clk);
         #1;
         cyc++;
         got = rdy_a[inst];
      end
      de_a[inst] = 1'b0;
      ie_a[inst] = 1'b0;
      if (use_d) begin
         if (rw)
            mwords[inst][widx(da)] = dd;
         else
            exp_dout[inst] = mwords[inst][widx(da)];
      end
      if (use_i)
         exp_iout[inst] = mwords[inst][widx(ia)];
      checkOutput({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
      checkOutput({tag, "_dout"}, dout_a[inst], exp_dout[inst]);
      checkOutput({tag, "_iout"}, iout_a[inst], exp_iout[inst]);
      @(posedge clk);
      #1;
      checkOutput({tag, "_rdy_pulse"}, 32'(rdy_a[inst]), 32'd0);
   endtask

   initial begin
      int slots [8];
      int s;
      int t;
      int op;

      for (int i = 0; i < 2; i++) begin
         rst_a[i] = 1'b0;  ie_a[i] = 1'b0;  de_a[i] = 1'b0;  drw_a[i] = 1'b0;
         iaddr_a[i] = '0;  daddr_a[i] = '0; din_a[i] = '0;
         exp_iout[i] = '0; exp_dout[i] = '0;
      end
      for (int i = 0; i < 8; i++) slots[i] = 300 + i * 13;

      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         checkOutput("reset_rdy", 32'(rdy_a[i]), 32'd0);
         checkOutput("reset_iout", iout_a[i], 32'd0);
         checkOutput("reset_dout", dout_a[i], 32'd0);
      end
      @(negedge clk);
      rst_a[0] = 1'b1;
      rst_a[1] = 1'b1;

      // Reset during the low-half write leaves only the high half updated.
      applyStimulus(0, 1, 0, 1, 32'h40, 32'h0, 32'h0000_1357, "preload40");
      @(negedge clk);
      de_a[0] = 1'b1;  drw_a[0] = 1'b1;  daddr_a[0] = 32'h40;  din_a[0] = 32'hDEAD_BEEF;
      @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
      rst_a[0] = 1'b0;
      #1;
      checkOutput("midreset_rdy", 32'(rdy_a[0]), 32'd0);
      checkOutput("midreset_iout", iout_a[0], 32'd0);
      checkOutput("midreset_dout", dout_a[0], 32'd0);
      de_a[0] = 1'b0;
      drw_a[0] = 1'b0;
      repeat (3) @(negedge clk);
      rst_a[0] = 1'b1;
      mwords[0][widx(32'h40)] = {16'hDEAD, mwords[0][widx(32'h40)][15:0]};
      exp_iout[0] = '0;
      exp_dout[0] = '0;
      applyStimulus(0, 1, 0, 0, 32'h40, 32'h0, 32'h0, "read40");

      // Directed write/read, fetch, simultaneous write+fetch, aliasing.
      applyStimulus(0, 1, 0, 1, 32'h100, 32'h0, 32'h1234_5678, "wr100");
      applyStimulus(0, 1, 0, 0, 32'h100, 32'h0, 32'h0, "rd100");
      applyStimulus(0, 1, 0, 1, 32'h200, 32'h0, 32'hCAFE_F00D, "pre200");
      applyStimulus(0, 0, 1, 0, 32'h0, 32'h200, 32'h0, "fetch200");
      applyStimulus(0, 1, 1, 1, 32'h300, 32'h300, 32'hA5A5_0F0F, "wrfetch300");
      applyStimulus(0, 1, 0, 1, 32'h2000, 32'h0, 32'h1111_2222, "wr2000");
      applyStimulus(0, 1, 0, 0, 32'h0000, 32'h0, 32'h0, "rd0alias");

      // Zero-wait instance: single and dual latency.
      applyStimulus(1, 1, 0, 1, 32'h2000, 32'h0, 32'h1111_2222, "w0_wr2000");
      applyStimulus(1, 1, 0, 0, 32'h0000, 32'h0, 32'h0, "w0_rd0");
      applyStimulus(1, 1, 0, 1, 32'h300, 32'h0, 32'h5A5A_F0F0, "w0_wr300");
      applyStimulus(1, 1, 1, 0, 32'h2000, 32'h300, 32'h0, "w0_dual");

      // Randomized mixed traffic on both instances over a pool of preloaded words.
      for (int inst = 0; inst < 2; inst++) begin
         for (int i = 0; i < 8; i++)
            applyStimulus(inst, 1, 0, 1, alias_of(slots[i]), 32'h0, $urandom, "rnd_pre");
         for (int n = 0; n < 20; n++) begin
            s  = slots[$urandom_range(0, 7)];
            t  = slots[$urandom_range(0, 7)];
            op = $urandom_range(0, 4);
            case (op)
               0: applyStimulus(inst, 1, 0, 1, alias_of(s), 32'h0, $urandom, "rnd_wr");
               1: applyStimulus(inst, 1, 0, 0, alias_of(s), 32'h0, 32'h0, "rnd_rd");
               2: applyStimulus(inst, 0, 1, 0, 32'h0, alias_of(t), 32'h0, "rnd_fetch");
               3: applyStimulus(inst, 1, 1, 0, alias_of(s), alias_of(t), 32'h0, "rnd_rdfetch");
               default: applyStimulus(inst, 1, 1, 1, alias_of(s), alias_of(t), $urandom, "rnd_wrfetch");
            endcase
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
